unary_result_encoder: RTL

Downstream stage of the `UnaryAdder` that consumes its 2N-bit thermometer-coded sum and produces the same value in binary and in reflected Gray code. It also flags a thermometer-code violation ("bubble"). This gives the unary adder path the same result format as `gray_adder` and `BinaryAdder`, so the three adders can be compared directly. It uses the codebase's start/done handshake: the adder's `done` drives `start`.

---
 rtl/unary_pkg.sv | 27 ++
 rtl/thermo_scan_counter.sv | 89 ++++++++
 rtl/unary_result_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// ----------------------------------------------------------------------------
// unary_pkg
// Shared definitions for the unary adder result path:
//   enc_state_t - control states of unary_result_encoder
//   enc_width   - binary/Gray output width for an N-operand unary adder
//                 (2N-bit thermometer input, values 0..2N)
//   bin2gray    - reflected binary-to-Gray conversion (32-bit; callers
//                 truncate to their own width)
// ----------------------------------------------------------------------------
package unary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_ENCODE = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_t;

    function automatic int unsigned enc_width(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage : unary_pkg

// File: rtl/thermo_scan_counter.sv
// ----------------------------------------------------------------------------
// thermo_scan_counter
// Serial thermometer-code scanner. On load the input word is captured into a
// shadow register and the scan state is cleared; each step examines one bit,
// LSB first, counting leading ones and flagging any 1 seen above a 0.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture data_in, clear cnt/idx/seen_zero/err
//   step      - process shadow bit sh[idx], advance idx
//   data_in   - 2N-bit thermometer code
//   cnt       - leading-ones count so far
//   err       - bubble detected (1 above a 0)
//   last      - idx points at the final bit (2N-1)
// ----------------------------------------------------------------------------
module thermo_scan_counter
    import unary_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned W  = enc_width(N),
    localparam int unsigned IW = $clog2(2 * N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [2*N-1:0] data_in,
    output logic [W-1:0]   cnt,
    output logic           err,
    output logic           last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    logic [2*N-1:0] sh_q, sh_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           seen_zero_q, seen_zero_d;
    logic           err_q, err_d;

    always_comb begin
        sh_d        = sh_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        seen_zero_d = seen_zero_q;
        err_d       = err_q;

        if (load) begin
            sh_d        = data_in;
            idx_d       = '0;
            cnt_d       = '0;
            seen_zero_d = 1'b0;
            err_d       = 1'b0;
        end else if (step) begin
            if (sh_q[idx_q]) begin
                // A 1 after a 0 is a bubble: flag it, but do not count it.
                if (seen_zero_q) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end else begin
                seen_zero_d = 1'b1;
            end
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            seen_zero_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            seen_zero_q <= seen_zero_d;
            err_q       <= err_d;
        end
    end

    assign cnt  = cnt_q;
    assign err  = err_q;
    assign last = (idx_q == LAST_IDX);

endmodule : thermo_scan_counter

// File: rtl/unary_result_encoder.sv
// ----------------------------------------------------------------------------
// unary_result_encoder
// Converts the 2N-bit thermometer-coded sum of the unary adder into binary
// and reflected Gray code, flagging thermometer bubbles. Start/done
// handshake; fixed latency of 2N+1 cycles from an accepted start.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   start    - one-cycle request, honoured only in IDLE or DONE
//   data_in  - 2N-bit thermometer code (bit 0 = LSB)
//   bin_out  - leading-ones count in binary
//   gray_out - bin_out in reflected Gray code
//   err      - a 1 was found above a 0
//   busy     - scan/encode in progress
//   done     - result valid; held until the next accepted start or rst
// ----------------------------------------------------------------------------
module unary_result_encoder
    import unary_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = enc_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] data_in,
    output logic [W-1:0]   bin_out,
    output logic [W-1:0]   gray_out,
    output logic           err,
    output logic           busy,
    output logic           done
);

    enc_state_t state_q, state_d;

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic         err_q, err_d;

    logic         load;
    logic         step;
    logic [W-1:0] scan_cnt;
    logic         scan_err;
    logic         scan_last;

    thermo_scan_counter #(
        .N (N)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .data_in (data_in),
        .cnt     (scan_cnt),
        .err     (scan_err),
        .last    (scan_last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        bin_d   = bin_q;
        gray_d  = gray_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step = 1'b1;
                if (scan_last) begin
                    state_d = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                bin_d   = scan_cnt;
                gray_d  = W'(bin2gray(32'(scan_cnt)));
                err_d   = scan_err;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Previous result stays visible while the next one is scanned.
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign err      = err_q;
    assign busy     = (state_q == ST_SCAN) || (state_q == ST_ENCODE);
    assign done     = (state_q == ST_DONE);

endmodule : unary_result_encoder
